// File: rtl/button_bank_if.sv
// Button bank signal bundle: raw button levels and repeat enables in, debounced levels and pulses out.
// Latency: none; this file only groups wires.
// Backpressure: none; every signal is a plain per-channel level or pulse.
interface button_bank_if #(
    parameter int N_BUTTONS = 4
);
    logic [N_BUTTONS-1:0] entrada;
    logic [N_BUTTONS-1:0] repeat_en;
    logic [N_BUTTONS-1:0] held;
    logic [N_BUTTONS-1:0] pressed;
    logic [N_BUTTONS-1:0] released;

    modport master (
        output entrada,
        output repeat_en,
        input  held,
        input  pressed,
        input  released
    );

    modport slave (
        input  entrada,
        input  repeat_en,
        output held,
        output pressed,
        output released
    );
endinterface

// File: rtl/button_bank.sv
// Multi-channel push-button front end: synchroniser, debouncer and press/hold/auto-repeat FSM per channel.
// Latency: held rises DEBOUNCE_CYCLES+1 edges after the first low sample; pressed pulses one edge later.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module button_bank #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic          clock,
    input logic          reset,
    button_bank_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = (REPEAT_DELAY > REPEAT_PERIOD) ? $clog2(REPEAT_DELAY) : $clog2(REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [N_BUTTONS-1:0] s1;
    logic [N_BUTTONS-1:0] s2;
    logic [N_BUTTONS-1:0] stable;
    logic [N_BUTTONS-1:0] press_v;
    logic [N_BUTTONS-1:0] rel_v;

    // Two-flop synchroniser; idles at the released (high) level out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= bus.entrada;
            s2 <= s1;
        end
    end

    assign bus.held     = stable;
    assign bus.pressed  = press_v;
    assign bus.released = rel_v;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic          raw;
        logic          stable_q;
        logic [CW-1:0] cnt;
        state_t        state;
        state_t        state_nxt;
        logic [TW-1:0] timer;
        logic [TW-1:0] timer_nxt;
        logic          press_nxt;
        logic          rel_nxt;
        logic          press_q;
        logic          rel_q;

        assign raw        = ~s2[i];
        assign stable[i]  = stable_q;
        assign press_v[i] = press_q;
        assign rel_v[i]   = rel_q;

        // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clock) begin
            if (!reset) begin
                stable_q <= 1'b0;
                cnt      <= '0;
            end else if (raw == stable_q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                stable_q <= raw;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        // FSM state, repeat timer and registered pulse outputs.
        always_ff @(posedge clock) begin
            if (!reset) begin
                state   <= IDLE;
                timer   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                timer   <= timer_nxt;
                press_q <= press_nxt;
                rel_q   <= rel_nxt;
            end
        end

        // Next state and timer; release always wins over a repeat falling due on the same cycle.
        always_comb begin
            state_nxt = state;
            timer_nxt = timer;
            case (state)
                IDLE: begin
                    if (stable_q) begin
                        state_nxt = HOLD;
                        timer_nxt = '0;
                    end
                end
                HOLD: begin
                    if (!stable_q) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (!bus.repeat_en[i]) begin
                        timer_nxt = '0;
                    end else if (timer == DELAY_LAST) begin
                        state_nxt = REPEAT;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!stable_q) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (!bus.repeat_en[i]) begin
                        state_nxt = HOLD;
                        timer_nxt = '0;
                    end else if (timer == PERIOD_LAST) begin
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end

        // Pulse decode: pressed on first press and each repeat, released on debounced release.
        always_comb begin
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            case (state)
                IDLE:    press_nxt = stable_q;
                HOLD: begin
                    rel_nxt   = ~stable_q;
                    press_nxt = stable_q & bus.repeat_en[i] & (timer == DELAY_LAST);
                end
                REPEAT: begin
                    rel_nxt   = ~stable_q;
                    press_nxt = stable_q & bus.repeat_en[i] & (timer == PERIOD_LAST);
                end
                default: begin
                    press_nxt = 1'b0;
                    rel_nxt   = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
Parametrised multi-channel front end for the active-low push buttons (paddle left/right, start, pause). Each channel has a two-flop synchroniser, a counter-based debouncer, and a press/hold/auto-repeat FSM. Each channel produces a debounced level plus single-cycle pressed/released pulses. Pressed pulses repeat while the button is held, so paddle control works by holding a button.

Parameters:
N_BUTTONS, 4, number of independent channels (>=1)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (>=2)
REPEAT_DELAY, 25000000, cycles from first pressed pulse to first repeat pulse (>=2)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=2)
(internal counter widths derived with $clog2 of the respective parameter; no overflow possible)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
entrada  input  N_BUTTONS  raw button inputs, active-low (0 = pressed), asynchronous
repeat_en  input  N_BUTTONS  per-channel auto-repeat enable, synchronous
held  output  N_BUTTONS  debounced level, 1 = pressed
pressed  output  N_BUTTONS  one-cycle pulse per press and per repeat
released  output  N_BUTTONS  one-cycle pulse on debounced release

Behaviour:
- Reset (reset==0 at a clock edge) overrides everything, all channels:
  - sync flops = 1; stable = 0; debounce counter = 0; FSM = IDLE; timer = 0.
  - held = pressed = released = 0.
- Reset mid-operation:
  - Outputs clear at that edge; no released pulse is generated.
  - A button still low after reset is treated as a new press, after the full debounce latency.
- Synchroniser: s1 <= entrada[i]; s2 <= s1. Each channel samples `raw = ~s2`.
- Debouncer, per channel:
  - raw == stable: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= raw and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 is discarded.
  - held = stable.
- Latency: edge 0 is the first edge sampling entrada low.
  - held rises after edge DEBOUNCE_CYCLES+1.
  - pressed pulses after edge DEBOUNCE_CYCLES+2.
  - Release is symmetric: released pulses after edge DEBOUNCE_CYCLES+2 from the first edge sampling high.
- FSM per channel, with pressed/released registered and defaulting to 0 each cycle:
  - IDLE:
    - stable==1 -> pressed<=1, timer<=0, go HOLD.
  - HOLD:
    - stable==0 -> released<=1, timer<=0, go IDLE.
    - else if repeat_en==0 -> timer<=0, stay.
    - else if timer==REPEAT_DELAY-1 -> pressed<=1, timer<=0, go REPEAT.
    - else timer++.
  - REPEAT:
    - stable==0 -> released<=1, timer<=0, go IDLE.
    - else if repeat_en==0 -> timer<=0, go HOLD.
    - else if timer==REPEAT_PERIOD-1 -> pressed<=1, timer<=0.
    - else timer++.
- Simultaneous events:
  - Release takes priority over a repeat due on the same cycle; only released pulses.
  - pressed and released are never both 1 on a channel.
- Channels are fully independent; simultaneous activity on any subset has no cross-effect.
- Illegal FSM encodings return to IDLE with timer cleared.
- Pulse spacing: first repeat is REPEAT_DELAY cycles after the initial pulse; subsequent repeats are every REPEAT_PERIOD cycles.

Test Plan:
Bench parameters: N_BUTTONS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset: hold reset=0 for 3 cycles with entrada=4'b0000 -> held=pressed=released=0 throughout. Release reset with entrada=4'b1111 -> outputs stay 0.
2. Clean press: entrada[0] low at edge 0 and held 8 cycles, repeat_en=0 -> held[0]=1 after edge 5; a single pressed[0] pulse after edge 6; no repeats. Raise entrada[0] -> released[0] one-cycle pulse 6 edges later; held[0]=0.
3. Bounce rejection: entrada[2] low for 3 cycles, high 2, low 3, then high -> held, pressed and released stay 0 on every channel.
4. Auto-repeat: repeat_en[1]=1, entrada[1] low held 30 cycles -> pressed[1] pulses after edges 6, 16, 19, 22, 25, 28. Release -> exactly one released[1]; no pressed on the release cycle.
5. Mixed channels: channels 0 and 3 pressed together, repeat_en=4'b1000 -> both get an initial pulse on the same cycle. Only channel 3 repeats. Dropping repeat_en[3] mid-REPEAT stops pulses, with no spurious pulse.
6. Reset mid-hold: channel 1 in REPEAT, then reset=0 for 1 cycle with entrada[1] still low -> outputs 0 next cycle and no released pulse. After reset release, a fresh pressed[1] appears after DEBOUNCE_CYCLES+2 edges.
